// File: rtl/apb_master_if.sv
// Command, response and APB bus signals of the APB requester.
// master: requester side (apb_master); slave: sequencer/peripheral side.
interface apb_master_if #(
   parameter int addrWidth = 2,
   parameter int timerbits = 8
);
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_write;
   logic [addrWidth-1:0] cmd_addr;
   logic [timerbits-1:0] cmd_wdata;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [timerbits-1:0] rsp_rdata;
   logic                 rsp_err;
   logic                 rsp_timeout;

   logic                 sel;
   logic                 enable;
   logic                 write;
   logic [addrWidth-1:0] addr;
   logic [timerbits-1:0] wdata;
   logic [timerbits-1:0] rdata;
   logic                 ready;
   logic                 slverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  rsp_ready,
      input  rdata, ready, slverr,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output sel, enable, write, addr, wdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output rsp_ready,
      output rdata, ready, slverr,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  sel, enable, write, addr, wdata
   );
endinterface

// File: rtl/apb_master.sv
// APB requester: one command at a time, SETUP/ACCESS transfer, held response.
// Ports: clk, reset (sync, active-high), bus (apb_master_if.master).
module apb_master #(
   parameter int addrWidth     = 2,
   parameter int timerbits     = 8,
   parameter int timeoutCycles = 15
) (
   input logic          clk,
   input logic          reset,
   apb_master_if.master bus
);
   localparam int CW =
      (timeoutCycles > 0) ? $clog2(timeoutCycles + 1) : 1;
   localparam logic [CW:0] TO_LIM = (CW + 1)'(timeoutCycles);
   localparam bit TO_EN = (timeoutCycles != 0);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW:0]   cnt_nxt;
   logic          tmo;

   assign cnt_nxt = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
   // Abort on the wait state that would bring the count to the limit.
   assign tmo = TO_EN && (cnt_nxt == TO_LIM);

   // Gated by reset so the port reads 0 while reset is held.
   assign bus.cmd_ready = (state == IDLE) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         cnt             <= '0;
         bus.sel         <= 1'b0;
         bus.enable      <= 1'b0;
         bus.write       <= 1'b0;
         bus.addr        <= '0;
         bus.wdata       <= '0;
         bus.rsp_valid   <= 1'b0;
         bus.rsp_rdata   <= '0;
         bus.rsp_err     <= 1'b0;
         bus.rsp_timeout <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  state     <= SETUP;
                  cnt       <= '0;
                  bus.sel   <= 1'b1;
                  bus.write <= bus.cmd_write;
                  bus.addr  <= bus.cmd_addr;
                  bus.wdata <= bus.cmd_write ? bus.cmd_wdata : '0;
               end
            end
            SETUP: begin
               state      <= ACCESS;
               bus.enable <= 1'b1;
            end
            ACCESS: begin
               // ready has priority over a timeout on the same edge
               if (bus.ready) begin
                  state           <= RESP;
                  bus.sel         <= 1'b0;
                  bus.enable      <= 1'b0;
                  bus.rsp_valid   <= 1'b1;
                  bus.rsp_rdata   <= bus.write ? '0 : bus.rdata;
                  bus.rsp_err     <= bus.slverr;
                  bus.rsp_timeout <= 1'b0;
               end else if (tmo) begin
                  state           <= RESP;
                  bus.sel         <= 1'b0;
                  bus.enable      <= 1'b0;
                  bus.rsp_valid   <= 1'b1;
                  bus.rsp_rdata   <= '0;
                  bus.rsp_err     <= 1'b1;
                  bus.rsp_timeout <= 1'b1;
               end else begin
                  cnt <= cnt_nxt[CW-1:0];
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state         <= IDLE;
                  bus.rsp_valid <= 1'b0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master against a transfer-timeline model.
// Second instance exercises the disabled timeout.
module tb_apb_master;
   localparam int AW = 2;
   localparam int DW = 8;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic reset;
   logic reset0;

   always #5 clk = ~clk;

   apb_master_if #(.addrWidth(AW), .timerbits(DW)) b ();
   apb_master_if #(.addrWidth(AW), .timerbits(DW)) b0 ();

   apb_master #(
      .addrWidth(AW), .timerbits(DW), .timeoutCycles(TO)
   ) u_dut (
      .clk(clk), .reset(reset), .bus(b)
   );

   apb_master #(
      .addrWidth(AW), .timerbits(DW), .timeoutCycles(0)
   ) u_dut0 (
      .clk(clk), .reset(reset0), .bus(b0)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // expected outputs for the current cycle
   logic          chk_on = 1'b0;
   logic          chk_bus = 1'b0;
   logic          chk_rsp = 1'b0;
   logic          e_cmd_ready, e_sel, e_en, e_rsp_valid;
   logic          e_write, e_err, e_to;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wdata, e_rdata;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endfunction

   // model: number of ACCESS cycles for a slave that waits w cycles
   function automatic int n_access(int w, int t);
      if (t != 0 && w >= t) return t;
      return w + 1;
   endfunction

   function automatic bit is_to(int w, int t);
      return (t != 0) && (w >= t);
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         chk("cmd_ready", 32'(b.cmd_ready), 32'(e_cmd_ready));
         chk("sel", 32'(b.sel), 32'(e_sel));
         chk("enable", 32'(b.enable), 32'(e_en));
         chk("rsp_valid", 32'(b.rsp_valid), 32'(e_rsp_valid));
         if (chk_bus) begin
            chk("write", 32'(b.write), 32'(e_write));
            chk("addr", 32'(b.addr), 32'(e_addr));
            chk("wdata", 32'(b.wdata), 32'(e_wdata));
         end
         if (chk_rsp) begin
            chk("rsp_rdata", 32'(b.rsp_rdata), 32'(e_rdata));
            chk("rsp_err", 32'(b.rsp_err), 32'(e_err));
            chk("rsp_timeout", 32'(b.rsp_timeout), 32'(e_to));
         end
      end
   end

   // independent bus activity counters
   int   sel_tot = 0;
   int   en_tot = 0;
   int   rise_cyc = 0;
   logic rv_q = 1'b0;

   always @(negedge clk) begin
      if (b.sel) sel_tot <= sel_tot + 1;
      if (b.enable) en_tot <= en_tot + 1;
      if (b.rsp_valid && !rv_q) rise_cyc <= cyc;
      rv_q <= b.rsp_valid;
   end

   int t_acc, sel_base, en_base;
   int last_lat, last_en, last_sel;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_slave();
      b.ready  = 1'($urandom);
      b.slverr = 1'($urandom);
      b.rdata  = 8'($urandom);
   endtask

   task automatic rnd_cmd();
      b.cmd_valid = 1'($urandom);
      b.cmd_write = 1'($urandom);
      b.cmd_addr  = 2'($urandom);
      b.cmd_wdata = 8'($urandom);
   endtask

   task automatic exp_idle();
      e_cmd_ready = 1'b1;
      e_sel       = 1'b0;
      e_en        = 1'b0;
      e_rsp_valid = 1'b0;
      chk_bus     = 1'b0;
      chk_rsp     = 1'b0;
   endtask

   task automatic exp_zero(input logic crdy);
      e_cmd_ready = crdy;
      e_sel       = 1'b0;
      e_en        = 1'b0;
      e_rsp_valid = 1'b0;
      chk_bus     = 1'b1;
      e_write     = 1'b0;
      e_addr      = '0;
      e_wdata     = '0;
      chk_rsp     = 1'b1;
      e_rdata     = '0;
      e_err       = 1'b0;
      e_to        = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         exp_idle();
         b.cmd_valid = 1'b0;
         rnd_slave();
         tick();
      end
   endtask

   // Starts in an idle cycle; returns in the idle cycle after completion.
   task automatic xfer(input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int w,
                       input logic [DW-1:0] rd, input bit se,
                       input int dly, input int rst_at);
      int na;
      bit tmo;
      na  = n_access(w, TO);
      tmo = is_to(w, TO);
      exp_idle();
      b.cmd_valid = 1'b1;
      b.cmd_write = wr;
      b.cmd_addr  = a;
      b.cmd_wdata = d;
      b.rsp_ready = 1'b0;
      rnd_slave();
      tick();
      t_acc    = cyc;
      sel_base = sel_tot;
      en_base  = en_tot;
      e_cmd_ready = 1'b0;
      e_sel       = 1'b1;
      e_en        = 1'b0;
      chk_bus     = 1'b1;
      e_write     = wr;
      e_addr      = a;
      e_wdata     = wr ? d : '0;
      rnd_cmd();
      rnd_slave();
      tick();
      e_en = 1'b1;
      for (int i = 0; i < na; i++) begin
         rnd_cmd();
         if (i == w) begin
            b.ready  = 1'b1;
            b.rdata  = rd;
            b.slverr = se;
         end else begin
            b.ready  = 1'b0;
            b.slverr = 1'($urandom);
            b.rdata  = 8'($urandom);
         end
         if (i == rst_at) reset = 1'b1;
         tick();
         if (i == rst_at) begin
            reset       = 1'b0;
            b.cmd_valid = 1'b0;
            b.ready     = 1'b0;
            exp_zero(1'b1);
            tick();
            exp_idle();
            return;
         end
      end
      e_sel       = 1'b0;
      e_en        = 1'b0;
      e_rsp_valid = 1'b1;
      chk_bus     = 1'b0;
      chk_rsp     = 1'b1;
      e_rdata     = (wr || tmo) ? '0 : rd;
      e_err       = tmo ? 1'b1 : se;
      e_to        = tmo;
      for (int j = 0; j <= dly; j++) begin
         rnd_cmd();
         rnd_slave();
         b.rsp_ready = (j == dly);
         tick();
      end
      b.rsp_ready = 1'b0;
      b.cmd_valid = 1'b0;
      exp_idle();
      last_lat = rise_cyc - t_acc + 1;
      last_en  = en_tot - en_base;
      last_sel = sel_tot - sel_base;
   endtask

   initial begin
      int hold;
      reset = 1'b1;
      reset0 = 1'b1;
      b.cmd_valid = 0; b.cmd_write = 0; b.cmd_addr = '0;
      b.cmd_wdata = '0; b.rsp_ready = 0; b.rdata = '0;
      b.ready = 0; b.slverr = 0;
      b0.cmd_valid = 0; b0.cmd_write = 0; b0.cmd_addr = '0;
      b0.cmd_wdata = '0; b0.rsp_ready = 0; b0.rdata = '0;
      b0.ready = 0; b0.slverr = 0;
      tick();
      exp_zero(1'b0);
      chk_on = 1'b1;
      tick();
      reset = 1'b0;
      exp_zero(1'b1);
      tick();

      chk("model_w0", 32'(n_access(0, 15)), 32'd1);
      chk("model_w3", 32'(n_access(3, 15)), 32'd4);
      chk("model_w14", 32'(n_access(14, 15)), 32'd15);
      chk("model_stuck", 32'(n_access(40, 15)), 32'd15);
      chk("model_to14", 32'(is_to(14, 15)), 32'd0);
      chk("model_t0", 32'(is_to(99, 0)), 32'd0);

      xfer(1, 2'd1, 8'h2A, 0, 8'h00, 0, 0, -1);
      chk("wr0_lat", 32'(last_lat), 32'd3);
      chk("wr0_en", 32'(last_en), 32'd1);
      chk("wr0_sel", 32'(last_sel), 32'd2);

      xfer(0, 2'd2, 8'h00, 3, 8'h37, 0, 0, -1);
      chk("rd3_lat", 32'(last_lat), 32'd6);
      chk("rd3_en", 32'(last_en), 32'd4);

      xfer(1, 2'd2, 8'h55, 1, 8'h00, 1, 0, -1);
      chk("slverr_lat", 32'(last_lat), 32'd4);

      xfer(0, 2'd1, 8'h00, 20, 8'hAA, 0, 0, -1);
      chk("tmo_lat", 32'(last_lat), 32'd17);
      chk("tmo_en", 32'(last_en), 32'd15);

      xfer(0, 2'd3, 8'h00, 14, 8'h5A, 0, 0, -1);
      chk("edge_lat", 32'(last_lat), 32'd17);
      chk("edge_en", 32'(last_en), 32'd15);

      xfer(0, 2'd0, 8'h00, 0, 8'h11, 0, 5, -1);
      chk("bp_lat", 32'(last_lat), 32'd3);
      xfer(1, 2'd3, 8'hC3, 0, 8'h00, 0, 0, -1);
      chk("bp_next_lat", 32'(last_lat), 32'd3);

      xfer(0, 2'd2, 8'h00, 5, 8'h99, 0, 0, 2);
      xfer(0, 2'd2, 8'h00, 1, 8'h66, 0, 0, -1);
      chk("post_rst_lat", 32'(last_lat), 32'd4);

      for (int n = 0; n < 60; n++) begin
         int w, na, ra;
         w  = ($urandom % 6 == 0) ? int'($urandom_range(10, 20))
                                  : int'($urandom_range(0, 3));
         na = n_access(w, TO);
         ra = ($urandom % 10 == 0) ? int'($urandom_range(0, na - 1))
                                   : -1;
         xfer(1'($urandom), 2'($urandom), 8'($urandom), w,
              8'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), ra);
         idle_cycles(int'($urandom_range(0, 2)));
      end

      // timeout disabled: a stuck slave keeps the transfer open
      exp_idle();
      b.cmd_valid = 1'b0;
      tick();
      reset0 = 1'b0;
      b0.cmd_valid = 1'b1;
      b0.cmd_write = 1'b0;
      b0.cmd_addr  = 2'd2;
      tick();
      b0.cmd_valid = 1'b0;
      tick();
      hold = 0;
      for (int i = 0; i < 40; i++) begin
         if (b0.sel && b0.enable && !b0.rsp_valid) hold++;
         b0.ready = 1'b0;
         tick();
      end
      chk("t0_hold", 32'(hold), 32'd40);
      b0.ready = 1'b1;
      b0.rdata = 8'h5C;
      tick();
      b0.ready = 1'b0;
      chk("t0_valid", 32'(b0.rsp_valid), 32'd1);
      chk("t0_rdata", 32'(b0.rsp_rdata), 32'h5C);
      chk("t0_err", 32'(b0.rsp_err), 32'd0);
      chk("t0_timeout", 32'(b0.rsp_timeout), 32'd0);
      b0.rsp_ready = 1'b1;
      tick();
      b0.rsp_ready = 1'b0;
      chk("t0_cmd_ready", 32'(b0.cmd_ready), 32'd1);

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that drives the peripheral bus for our APB slaves, such as the timer (status/goal/current registers).
- Accepts one command at a time from a simple valid/ready command port and runs the two-phase SETUP/ACCESS transfer.
- Returns read data, slave error and timeout status on a held response port.
- Sits between the CPU-side/test-sequencer logic and the APB slaves.

Parameters:
- addrWidth, 2: width of cmd_addr and addr.
- timerbits, 8: data width of cmd_wdata, wdata, rdata and rsp_rdata.
- timeoutCycles, 15: ACCESS cycles without ready before the transfer is aborted; 0 disables the timeout.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  addrWidth  target register address.
- cmd_wdata  input  timerbits  write data; ignored for reads.
- rsp_valid  output  1  response available; held until taken.
- rsp_ready  input  1  consumer takes the response.
- rsp_rdata  output  timerbits  read data; 0 for writes and timeouts.
- rsp_err  output  1  slverr sampled, or timeout.
- rsp_timeout  output  1  transfer aborted by timeout.
- sel  output  1  APB select.
- enable  output  1  APB enable (ACCESS phase).
- write  output  1  APB direction.
- addr  output  addrWidth  APB address.
- wdata  output  timerbits  APB write data.
- rdata  input  timerbits  APB read data.
- ready  input  1  APB slave ready.
- slverr  input  1  APB slave error.

Behaviour:
- Reset values: all outputs 0 (including cmd_ready) for the cycle(s) reset is high. The state machine goes to IDLE and the wait counter clears. In the first cycle after reset releases, cmd_ready = 1.
- State machine: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE: cmd_ready = 1; sel = enable = 0.
  - On cmd_valid && cmd_ready at an edge, latch write, addr and wdata from the command; go to SETUP.
  - Reads drive wdata = 0.
- SETUP (exactly 1 cycle): sel = 1, enable = 0, cmd_ready = 0; go to ACCESS.
- ACCESS: sel = 1, enable = 1. addr, write and wdata are unchanged from SETUP.
  - ready = 1 sampled at an edge: capture rsp_rdata (rdata for reads, 0 for writes) and rsp_err = slverr; rsp_timeout = 0; go to RESP.
  - ready = 0: increment the wait counter. If timeoutCycles != 0 and the counter reaches timeoutCycles, go to RESP with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - Counter width is clog2(timeoutCycles+1), minimum 1. It clears on entry to SETUP.
- RESP: sel = enable = 0 (the bus returns to idle in the cycle after completion); rsp_valid = 1.
  - rsp_* are stable while rsp_valid is high.
  - rsp_valid && rsp_ready at an edge -> IDLE. The next command can be accepted at the following edge, so there is 1 idle bus cycle minimum between transfers.
- Latency: command accepted at edge N gives SETUP in cycle N+1 and ACCESS in N+2. With zero wait states, rsp_valid = 1 in cycle N+3. Each wait state adds 1 cycle.
- cmd_* changes while cmd_ready = 0 are ignored.
- No pipelining: one outstanding transfer.
- ready and slverr are ignored outside ACCESS.
- Simultaneous ready = 1 and timeout threshold on the same edge: ready wins, so this is a normal completion with rsp_timeout = 0.
- Reset mid-transfer (SETUP, ACCESS or RESP): the next edge drops sel and enable, discards any pending response and clears the counter; no rsp_valid is produced for the aborted command.
- Address range is not checked; slaves report errors through slverr.

Test Plan:
- Write addr=1 data=0x2A, slave ready in first ACCESS cycle: sel high 2 cycles, enable high 1 cycle, wdata=0x2A; rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Read addr=2, slave holds ready=0 for 3 ACCESS cycles then returns rdata=0x37: enable high 4 cycles; rsp_rdata=0x37, rsp_err=0, rsp_valid at N+6.
- Write addr=2 with slverr=1 at ready: rsp_err=1, rsp_timeout=0.
- Read with ready stuck at 0, timeoutCycles=15: after 15 ACCESS cycles sel/enable drop; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with timeoutCycles=0: the transfer is never aborted.
- Back-pressure: rsp_ready=0 for 5 cycles after completion: rsp_* held constant, cmd_ready=0, no bus activity. A second command issued right after rsp_ready=1 gets its SETUP 2 cycles after the response handshake edge.
- Assert reset for 1 cycle during ACCESS of a read: sel/enable/rsp_valid = 0 next cycle, cmd_ready = 1 after release, and the following command completes normally.
